// File: rtl/tt_scan_pkg.sv
// Shared types and constants for the truth-table scan controller.
//   state_e    : controller states (IDLE, RUN, DONE)
//   NUM_VEC    : number of input vectors of a 3-input unit
//   VEC_W      : width of the vector index
//   TT_W       : width of a captured/expected truth table
//   hold_cnt_w : width of a counter that must reach HOLD_CYCLES-1 (at least 1 bit)
package tt_scan_pkg;

    localparam int unsigned NUM_VEC = 8;
    localparam int unsigned VEC_W   = 3;
    localparam int unsigned TT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned hold_cnt_w(input int unsigned hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

endpackage

// File: rtl/tt_hold_counter.sv
// Counts the cycles a vector has been applied to the unit under test.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   clear   : synchronous return to zero (wins over enable)
//   enable  : advance by one, wrapping to zero after HOLD_CYCLES-1
//   last    : count is at HOLD_CYCLES-1, i.e. this cycle closes the hold window
module tt_hold_counter
    import tt_scan_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int unsigned CntW = hold_cnt_w(HOLD_CYCLES);
    localparam logic [CntW-1:0] LastVal = CntW'(HOLD_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == LastVal);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_scan_ctrl.sv
// Exhaustive scan sequencer for a 3-input, 1-output combinational unit.
// Steps the unit through vectors 000..111 (dut_a is the MSB), holding each for
// HOLD_CYCLES cycles, samples dut_out at the end of each hold window into an
// 8-bit truth table and compares it against the table latched at start.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : begin a scan (accepted in IDLE only)
//   abort             : cancel a running scan, keeps partial capture
//   expected[7:0]     : expected truth table, bit i = output for vector i
//   dut_out           : output of the unit under test
//   dut_a/dut_b/dut_c : unit inputs, {dut_a,dut_b,dut_c} = vector index
//   busy              : scan in progress
//   done              : one-cycle completion pulse
//   pass              : captured == expected, valid from done until next start
//   captured[7:0]     : sampled truth table
//   mismatch[7:0]     : captured ^ expected, valid from done until next start
module tt_scan_ctrl
    import tt_scan_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] expected,
    input  logic            dut_out,
    output logic            dut_a,
    output logic            dut_b,
    output logic            dut_c,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [TT_W-1:0] captured,
    output logic [TT_W-1:0] mismatch
);

    localparam logic [VEC_W-1:0] LastVec = VEC_W'(NUM_VEC - 1);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [VEC_W-1:0] dut_vec_q, dut_vec_d;
    logic [TT_W-1:0]  exp_q, exp_d;
    logic [TT_W-1:0]  cap_q, cap_d;
    logic [TT_W-1:0]  mis_q, mis_d;
    logic             pass_q, pass_d;

    logic hold_clear;
    logic hold_en;
    logic hold_last;

    tt_hold_counter #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (hold_clear),
        .enable (hold_en),
        .last   (hold_last)
    );

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        exp_d      = exp_q;
        cap_d      = cap_q;
        mis_d      = mis_q;
        pass_d     = pass_q;
        hold_clear = 1'b1;
        hold_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    vec_d   = '0;
                    exp_d   = expected;
                    cap_d   = '0;
                    mis_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                hold_clear = 1'b0;
                hold_en    = 1'b1;
                if (abort) begin
                    // Abort wins over a sample due on the same edge.
                    state_d    = IDLE;
                    hold_clear = 1'b1;
                    pass_d     = 1'b0;
                end else if (hold_last) begin
                    cap_d[vec_q] = dut_out;
                    vec_d        = vec_q + 1'b1;
                    if (vec_q == LastVec) begin
                        // Compare on the final sampling edge so that mismatch and
                        // pass are already valid in the cycle done is high.
                        state_d = DONE;
                        mis_d   = cap_d ^ exp_q;
                        pass_d  = ~|(cap_d ^ exp_q);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Unit inputs follow the vector only while scanning, 000 otherwise.
        dut_vec_d = (state_d == RUN) ? vec_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            dut_vec_q <= '0;
            exp_q     <= '0;
            cap_q     <= '0;
            mis_q     <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            dut_vec_q <= dut_vec_d;
            exp_q     <= exp_d;
            cap_q     <= cap_d;
            mis_q     <= mis_d;
            pass_q    <= pass_d;
        end
    end

    assign {dut_a, dut_b, dut_c} = dut_vec_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign pass     = pass_q;
    assign captured = cap_q;
    assign mismatch = mis_q;

endmodule

// File: tb/tb_tt_scan_ctrl.sv
`timescale 1ns/1ps
module tb_tt_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] expected = 8'h00;
    logic [7:0] unit_tt = 8'h00;

    // Instance 0 uses HOLD_CYCLES=4, instance 1 uses HOLD_CYCLES=1.
    logic [1:0] a_w, b_w, c_w, busy_w, done_w, pass_w, out_w;
    logic [7:0] cap_w [2];
    logic [7:0] mis_w [2];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign out_w[0] = unit_tt[{a_w[0], b_w[0], c_w[0]}];
    assign out_w[1] = unit_tt[{a_w[1], b_w[1], c_w[1]}];

    tt_scan_ctrl #(.HOLD_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
        .dut_out(out_w[0]), .dut_a(a_w[0]), .dut_b(b_w[0]), .dut_c(c_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .captured(cap_w[0]), .mismatch(mis_w[0])
    );

    tt_scan_ctrl #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
        .dut_out(out_w[1]), .dut_a(a_w[1]), .dut_b(b_w[1]), .dut_c(c_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .captured(cap_w[1]), .mismatch(mis_w[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic int hold_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [7:0] low_mask(input int k);
        logic [8:0] m;
        m = (9'd1 << k) - 9'd1;
        return m[7:0];
    endfunction

    // Reference model: phase 0 idle, 1 scanning, 2 done cycle. n is the 1-based
    // cycle number inside the scan, s the number of vectors sampled so far.
    int         ph [2];
    int         n  [2];
    int         s  [2];
    logic [7:0] tt_l  [2];
    logic [7:0] exp_l [2];
    logic [7:0] mis_m [2];
    logic       pass_m [2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                ph[i] <= 0; n[i] <= 0; s[i] <= 0;
                tt_l[i] <= 8'h00; exp_l[i] <= 8'h00; mis_m[i] <= 8'h00; pass_m[i] <= 1'b0;
            end else if (ph[i] == 0) begin
                if (start) begin
                    ph[i] <= 1; n[i] <= 1; s[i] <= 0;
                    tt_l[i] <= unit_tt; exp_l[i] <= expected;
                    mis_m[i] <= 8'h00; pass_m[i] <= 1'b0;
                end
            end else if (ph[i] == 1) begin
                if (abort) begin
                    ph[i] <= 0;
                    pass_m[i] <= 1'b0;
                end else begin
                    if (n[i] % hold_of(i) == 0) s[i] <= n[i] / hold_of(i);
                    if (n[i] == 8 * hold_of(i)) begin
                        ph[i] <= 2;
                        mis_m[i] <= tt_l[i] ^ exp_l[i];
                        pass_m[i] <= (tt_l[i] == exp_l[i]);
                    end else begin
                        n[i] <= n[i] + 1;
                    end
                end
            end else begin
                ph[i] <= 0;
            end
        end
    end

    // Compare every cycle against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                logic [2:0] vec_m;
                vec_m = (ph[i] == 1) ? 3'((n[i] - 1) / hold_of(i)) : 3'd0;
                chk($sformatf("busy[%0d]", i), busy_w[i], ph[i] == 1);
                chk($sformatf("done[%0d]", i), done_w[i], ph[i] == 2);
                chk($sformatf("vec[%0d]", i), {a_w[i], b_w[i], c_w[i]}, vec_m);
                chk($sformatf("captured[%0d]", i), cap_w[i], tt_l[i] & low_mask(s[i]));
                chk($sformatf("mismatch[%0d]", i), mis_w[i], mis_m[i]);
                chk($sformatf("pass[%0d]", i), pass_w[i], pass_m[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 200;
        while ((ph[0] != 0 || ph[1] != 0 || busy_w != 2'b00) && budget > 0) begin
            tick();
            budget--;
        end
        chk("wait_idle busy", busy_w, 2'b00);
    endtask

    // One full scan with literal expectations on completion timing and results.
    task automatic run_scan(input logic [7:0] tt, input logic [7:0] ex, input logic [7:0] cap_req,
                            input logic [7:0] mis_req, input logic pass_req, input string tag);
        int d4, d1, c4, c1;
        logic [7:0] cap4, mis4, cap1;
        logic p4;
        d4 = 0; d1 = 0; c4 = 0; c1 = 0;
        cap4 = 8'h00; mis4 = 8'h00; cap1 = 8'h00; p4 = 1'b0;
        wait_idle();
        unit_tt = tt;
        expected = ex;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done_w[0]) begin
                c4++; d4 = c; cap4 = cap_w[0]; mis4 = mis_w[0]; p4 = pass_w[0];
            end
            if (done_w[1]) begin
                c1++; d1 = c; cap1 = cap_w[1];
            end
            tick();
        end
        chk({tag, " done cycle H4"}, d4, 33);
        chk({tag, " done count H4"}, c4, 1);
        chk({tag, " done cycle H1"}, d1, 9);
        chk({tag, " done count H1"}, c1, 1);
        chk({tag, " captured H4"}, cap4, cap_req);
        chk({tag, " mismatch H4"}, mis4, mis_req);
        chk({tag, " pass H4"}, p4, pass_req);
        chk({tag, " captured H1"}, cap1, cap_req);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        // Reset state.
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk("reset busy", busy_w[i], 1'b0);
            chk("reset done", done_w[i], 1'b0);
            chk("reset pass", pass_w[i], 1'b0);
            chk("reset vec", {a_w[i], b_w[i], c_w[i]}, 3'b000);
            chk("reset captured", cap_w[i], 8'h00);
            chk("reset mismatch", mis_w[i], 8'h00);
        end
        rst_n = 1'b1;
        tick();

        // Majority, XOR, and majority with a wrong expected table.
        run_scan(8'hE8, 8'hE8, 8'hE8, 8'h00, 1'b1, "maj");
        run_scan(8'h96, 8'h96, 8'h96, 8'h00, 1'b1, "xor");
        run_scan(8'hE8, 8'hE9, 8'hE8, 8'h01, 1'b0, "maj_bad");

        // start during RUN and DONE is ignored; held in the following IDLE it is taken.
        wait_idle();
        unit_tt = 8'hE8; expected = 8'hE8;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 36; c++) begin
            start = (c == 5 || c == 33 || c == 34);
            @(negedge clk);
            if (c == 33) chk("restart done at 33", done_w[0], 1'b1);
            if (c == 34) chk("restart idle at 34", busy_w[0], 1'b0);
            if (c == 35) chk("restart busy at 35", busy_w[0], 1'b1);
            tick();
        end
        start = 1'b0;

        // Abort in cycle 10 while vector 2 is applied.
        wait_idle();
        unit_tt = 8'h5B; expected = 8'h5B;
        start = 1'b1;
        tick();
        start = 1'b0;
        dn = 0;
        for (int c = 1; c <= 40; c++) begin
            abort = (c == 10);
            @(negedge clk);
            if (c == 10) chk("abort vec at 10", {a_w[0], b_w[0], c_w[0]}, 3'b010);
            if (c == 11) begin
                chk("abort busy", busy_w[0], 1'b0);
                chk("abort captured", cap_w[0], 8'h03);
                chk("abort pass", pass_w[0], 1'b0);
                chk("abort vec", {a_w[0], b_w[0], c_w[0]}, 3'b000);
            end
            if (done_w[0]) dn++;
            tick();
        end
        abort = 1'b0;
        chk("abort no done", dn, 0);

        // Asynchronous reset in cycle 20, then a fresh scan.
        wait_idle();
        unit_tt = 8'hE8; expected = 8'hE8;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        chk("pre-reset captured", cap_w[0], 8'h08);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset busy", busy_w[0], 1'b0);
        chk("async reset captured", cap_w[0], 8'h00);
        chk("async reset vec", {a_w[0], b_w[0], c_w[0]}, 3'b000);
        chk("async reset done", done_w[0], 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_scan(8'hE8, 8'hE8, 8'hE8, 8'h00, 1'b1, "post_reset");

        // Randomized scans with occasional aborts and stray start pulses.
        for (int it = 0; it < 25; it++) begin
            wait_idle();
            unit_tt = 8'($urandom);
            expected = ($urandom_range(0, 1) == 1) ? unit_tt
                       : unit_tt ^ (8'd1 << $urandom_range(0, 7));
            start = 1'b1;
            tick();
            for (int c = 1; c <= 36; c++) begin
                abort = ($urandom_range(0, 79) == 0);
                start = ($urandom_range(0, 15) == 0);
                tick();
            end
            abort = 1'b0;
            start = 1'b0;
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tt_scan_ctrl.md
# tt_scan_ctrl

Sequencer that exhaustively exercises a 3-input, 1-output combinational unit in hardware. It drives the unit's inputs through all eight combinations in binary order, from 000 to 111, with the first input as MSB. It samples the unit's output for each vector, assembles an 8-bit captured truth table, and compares it against an expected table. It sits between a control/status source and the combinational unit under test, replacing manual vector stepping.

## Interface
- HOLD_CYCLES, 4: cycles each vector is held before sampling. Legal range ≥1.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin scan; honoured only in IDLE
- abort  in  1  synchronous cancel of a running scan
- expected  in  8  expected truth table; bit i = output for vector i; latched at start
- dut_out  in  1  output of the unit under test
- dut_a, dut_b, dut_c  out  1 each  unit inputs; {dut_a,dut_b,dut_c} = vector index
- busy  out  1  high while scanning
- done  out  1  one-cycle pulse at scan completion
- pass  out  1  captured == expected; valid from done until next start
- captured  out  8  sampled truth table
- mismatch  out  8  captured ^ expected; valid from done until next start

## Operation
- Reset values: state IDLE, dut_a/b/c=0, busy=0, done=0, pass=0, captured=8'h00, mismatch=8'h00, vector index=0, hold counter=0, latched expected=8'h00.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → RUN; vec=0, hold=0, expected latched, captured cleared, pass=0, busy=1.
  - All other inputs are ignored.
- RUN:
  - hold increments each cycle.
  - When hold==HOLD_CYCLES-1: captured[vec] <= dut_out, hold <= 0, vec <= vec+1.
  - When vec==7 at that point → DONE.
  - start is ignored.
- RUN with abort=1: the abort takes priority over sampling in the same cycle.
  - Next state is IDLE, busy=0, no done pulse, pass=0.
  - captured keeps the partial contents.
- DONE: one cycle.
  - done=1, busy=0.
  - mismatch <= captured ^ expected_latched; pass <= (that value == 0).
  - Then IDLE. start asserted during DONE is ignored.
- dut_a/b/c are registered from vec and return to 000 in IDLE and DONE.
- The 3-bit vec wraps 7→0 by design; it is never used after the wrap.
- The hold counter is $clog2(HOLD_CYCLES) bits, minimum 1 bit.

## Timing
- Edge 0: start sampled. dut inputs show vector 0 from cycle 1.
- Vector k is applied during cycles 1+k·H through (k+1)·H, where H = HOLD_CYCLES.
- dut_out is sampled at the edge closing cycle (k+1)·H. The unit is combinational and settles within one cycle, so H=1 is legal.
- done is high during cycle 8H+1. pass and mismatch are valid from that cycle.
- Total start-to-done latency: 8H+1 cycles. With H=4, done is in cycle 33.
- busy is high in cycles 1 to 8H inclusive.
- Asynchronous reset at any point, including mid-RUN or in DONE, forces all reset values immediately. No done pulse is generated.
- start held high continuously: a new scan begins on the first IDLE cycle after DONE, i.e. back-to-back scans with a one-cycle IDLE gap.

## Structure
- Package tt_scan_pkg:
  - state enum {IDLE, RUN, DONE}
  - NUM_VEC=8, VEC_W=3, TT_W=8
- Sub-module tt_hold_counter: parameterised by HOLD_CYCLES, with inputs clear and enable and output last. The remainder of the block is the FSM plus the capture/compare registers.
- The unit under test is instantiated alongside this block at the same level, not inside it.

## Test plan
- Majority unit, H=4, expected=8'hE8, start pulsed → vectors 000 to 111 each held 4 cycles. Required: captured=8'hE8, done in cycle 33, pass=1, mismatch=8'h00.
- 3-input XOR unit, H=1, expected=8'h96 → done in cycle 9, captured=8'h96, pass=1.
- Majority unit, expected=8'hE9 → captured=8'hE8, mismatch=8'h01, pass=0, single done pulse.
- Majority unit, H=4, start pulsed again at cycles 5 and 33 → both ignored. At cycle 34, start is accepted only if held there; verify busy goes high at 35.
- abort=1 in cycle 10 (H=4, vector 2 active) → IDLE next cycle, busy=0, no done, pass=0, captured[1:0] kept, dut inputs 000.
- rst_n low in cycle 20 → all outputs 0 asynchronously. After release, a fresh start completes normally in 8H+1 cycles.
